// File: rtl/rx_frame_sched.sv
// Store-and-forward sequencer for the receive data/control FIFO pair.
// The write side tracks each frame into a small status queue; the read side releases only whole frames.
module rx_frame_sched #(
  parameter int CNT_W    = 8,
  parameter int FQ_DEPTH = 4,
  parameter int FQ_AW    = 2
) (
  input  logic rxclk_180,
  input  logic reset,
  input  logic receiving,
  input  logic recv_end,
  input  logic frame_err,
  input  logic fifo_full,
  input  logic fifo_empty,
  output logic fifo_wr_en,
  output logic fifo_rd_en,
  input  logic rx_out_ready,
  output logic rx_out_valid,
  output logic rx_sof,
  output logic rx_eof,
  output logic rx_good_frame,
  output logic rx_bad_frame,
  output logic rx_drop,
  output logic rx_overflow
);

  typedef enum logic [1:0] {W_IDLE, W_STORE, W_DROP} wstate_t;
  typedef enum logic {R_IDLE, R_READ} rstate_t;
  typedef logic [FQ_AW:0] qcnt_t;

  localparam qcnt_t FQ_FULL = qcnt_t'(FQ_DEPTH);

  wstate_t          wstate;
  rstate_t          rstate;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] rcnt;
  logic             trunc;
  logic             first;
  logic [FQ_AW:0]   wptr;
  logic [FQ_AW:0]   rptr;
  qcnt_t            count;
  logic [CNT_W-1:0] fq_words [FQ_DEPTH];
  logic [FQ_DEPTH-1:0] fq_bad;

  logic need_wr;
  logic wcnt_max;
  logic lose;
  logic reserve;
  logic end_store;
  logic release_slot;
  logic last_rd;
  logic head_bad;
  logic [CNT_W-1:0] head_words;

  assign need_wr      = receiving & ~recv_end;
  assign wcnt_max     = &wcnt;
  // A saturated word counter is treated like a full FIFO so long frames truncate instead of wrapping.
  assign fifo_wr_en   = reset & (wstate == W_STORE) & need_wr & ~fifo_full & ~trunc & ~wcnt_max;
  assign lose         = (wstate == W_STORE) & need_wr & ~trunc & (fifo_full | wcnt_max);
  assign reserve      = (wstate == W_IDLE) & receiving & (count < FQ_FULL);
  assign end_store    = (wstate == W_STORE) & recv_end;
  assign release_slot = end_store & (wcnt == '0);
  assign head_words   = fq_words[rptr[FQ_AW-1:0]];
  assign head_bad     = fq_bad[rptr[FQ_AW-1:0]];
  assign fifo_rd_en   = reset & (rstate == R_READ) & rx_out_ready & ~fifo_empty & (rcnt != '0);
  assign last_rd      = fifo_rd_en & (rcnt == CNT_W'(1));

  always_ff @(posedge rxclk_180) begin
    if (!reset) begin
      wstate        <= W_IDLE;
      rstate        <= R_IDLE;
      wcnt          <= '0;
      rcnt          <= '0;
      trunc         <= 1'b0;
      first         <= 1'b0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      fq_bad        <= '0;
      rx_out_valid  <= 1'b0;
      rx_sof        <= 1'b0;
      rx_eof        <= 1'b0;
      rx_good_frame <= 1'b0;
      rx_bad_frame  <= 1'b0;
      rx_drop       <= 1'b0;
      rx_overflow   <= 1'b0;
    end else begin
      rx_drop <= 1'b0;
      if (lose) begin
        trunc       <= 1'b1;
        rx_overflow <= 1'b1;
      end

      case (wstate)
        W_IDLE: begin
          if (receiving) wstate <= (count < FQ_FULL) ? W_STORE : W_DROP;
        end
        W_STORE: begin
          if (fifo_wr_en) wcnt <= wcnt + 1'b1;
          if (recv_end) begin
            wstate <= W_IDLE;
            wcnt   <= '0;
            trunc  <= 1'b0;
            if (wcnt == '0) begin
              rx_drop     <= 1'b1;
              rx_overflow <= 1'b1;
            end else begin
              fq_words[wptr[FQ_AW-1:0]] <= wcnt;
              fq_bad[wptr[FQ_AW-1:0]]   <= frame_err | trunc;
              wptr                      <= wptr + 1'b1;
            end
          end
        end
        W_DROP: begin
          if (recv_end) begin
            rx_drop     <= 1'b1;
            rx_overflow <= 1'b1;
            wstate      <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase

      // Data appears one cycle after the read strobe, so the framing marks are delayed to match.
      rx_out_valid  <= fifo_rd_en;
      rx_sof        <= fifo_rd_en & first;
      rx_eof        <= last_rd;
      rx_good_frame <= last_rd & ~head_bad;
      rx_bad_frame  <= last_rd & head_bad;

      case (rstate)
        R_IDLE: begin
          if (wptr != rptr) begin
            rcnt   <= head_words;
            first  <= 1'b1;
            rstate <= R_READ;
          end
        end
        R_READ: begin
          if (fifo_rd_en) begin
            rcnt  <= rcnt - 1'b1;
            first <= 1'b0;
            if (rcnt == CNT_W'(1)) begin
              rptr   <= rptr + 1'b1;
              rstate <= R_IDLE;
            end
          end
        end
        default: rstate <= R_IDLE;
      endcase

      count <= count + qcnt_t'(reserve) - qcnt_t'(release_slot) - qcnt_t'(last_rd);
    end
  end

endmodule

// File: tb/tb_rx_frame_sched.sv
// Bench for rx_frame_sched: models the data FIFO as a token queue and compares the delivered word
// stream against the frame list expected from the stimulus.
module tb_rx_frame_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset = 1'b0;
  logic receiving = 1'b0;
  logic recv_end = 1'b0;
  logic frame_err = 1'b0;
  logic rx_out_ready = 1'b0;
  logic fifo_full, fifo_empty;
  logic fifo_wr_en, fifo_rd_en;
  logic rx_out_valid, rx_sof, rx_eof, rx_good_frame, rx_bad_frame, rx_drop, rx_overflow;

  rx_frame_sched dut (
    .rxclk_180    (clk),
    .reset        (reset),
    .receiving    (receiving),
    .recv_end     (recv_end),
    .frame_err    (frame_err),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_rd_en   (fifo_rd_en),
    .rx_out_ready (rx_out_ready),
    .rx_out_valid (rx_out_valid),
    .rx_sof       (rx_sof),
    .rx_eof       (rx_eof),
    .rx_good_frame(rx_good_frame),
    .rx_bad_frame (rx_bad_frame),
    .rx_drop      (rx_drop),
    .rx_overflow  (rx_overflow)
  );

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] idx;
    logic       sof;
    logic       eof;
    logic       good;
    logic       bad;
  } ent_t;

  localparam int FIFO_CAP = 64;
  localparam int FQ_DEPTH = 4;

  ent_t        log_q[$];
  ent_t        exp_q[$];
  logic [15:0] fifo_q[$];
  logic [15:0] rd_data = '0;
  logic [15:0] cur_tok = '0;
  logic [15:0] pend_tok = '0;
  bit mdl_full = 1'b0, mdl_empty = 1'b1, force_full = 1'b0;
  bit pend_wr = 1'b0, pend_rd = 1'b0, pend_rst = 1'b1;
  int wr_total = 0, rd_total = 0, drop_total = 0, eof_total = 0;
  int checks = 0, passed = 0;
  int rdy_mode = 0;

  assign fifo_full  = mdl_full | force_full;
  assign fifo_empty = mdl_empty;

  // FIFO model and output monitor: apply the strobes of the edge just passed, log what the client sees,
  // then capture the strobes the DUT presents for the coming edge.
  always @(negedge clk) begin
    ent_t e;
    if (pend_rst) begin
      fifo_q.delete();
    end else begin
      if (pend_rd && fifo_q.size() > 0) rd_data = fifo_q.pop_front();
      if (pend_wr) fifo_q.push_back(pend_tok);
    end
    if (rx_out_valid || rx_sof || rx_eof || rx_good_frame || rx_bad_frame) begin
      e.id   = rx_out_valid ? rd_data[15:8] : 8'hff;
      e.idx  = rd_data[7:0];
      e.sof  = rx_sof;
      e.eof  = rx_eof;
      e.good = rx_good_frame;
      e.bad  = rx_bad_frame;
      log_q.push_back(e);
    end
    if (rx_eof) eof_total++;
    if (rx_drop) drop_total++;
    mdl_full  = fifo_q.size() >= FIFO_CAP;
    mdl_empty = fifo_q.size() == 0;
    #1;
    pend_wr  = fifo_wr_en;
    pend_rd  = fifo_rd_en;
    pend_tok = cur_tok;
    pend_rst = !reset;
    if (fifo_wr_en) wr_total++;
    if (fifo_rd_en) rd_total++;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       rx_out_ready = 1'b0;
        1:       rx_out_ready = 1'b1;
        default: rx_out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Expected words: a frame keeps the words accepted before the FIFO filled; any loss makes it bad.
  task automatic send_frame(input int id, input int n, input bit err, input int full_at, input bit dropped);
    int written;
    bit bad;
    ent_t e;
    written = (full_at >= 0 && full_at < n) ? full_at : n;
    bad = err | (written < n);
    if (!dropped) begin
      for (int k = 0; k < written; k++) begin
        e.id = 8'(id); e.idx = 8'(k);
        e.sof = (k == 0); e.eof = (k == written - 1);
        e.good = e.eof & ~bad; e.bad = e.eof & bad;
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
    receiving = 1'b1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cur_tok = {8'(id), 8'(i)};
      if (i == full_at) force_full = 1'b1;
    end
    @(posedge clk); #1;
    recv_end = 1'b1;
    frame_err = err;
    @(posedge clk); #1;
    receiving = 1'b0;
    recv_end = 1'b0;
    frame_err = 1'b0;
    force_full = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (log_q.size() < exp_q.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({fifo_wr_en, fifo_rd_en, rx_out_valid, rx_sof, rx_eof, rx_good_frame, rx_bad_frame, rx_drop, rx_overflow} !== 9'b0)
      $display("FAIL reset_outputs got %b want 0", {fifo_wr_en, fifo_rd_en, rx_out_valid, rx_sof, rx_eof,
               rx_good_frame, rx_bad_frame, rx_drop, rx_overflow});
    else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_good_frame();
    int w0, r0;
    rdy_mode = 1; log_q.delete(); exp_q.delete();
    w0 = wr_total; r0 = rd_total;
    send_frame(1, 3, 1'b0, -1, 1'b0);
    wait_drain();
    checks++;
    if (wr_total - w0 !== 3) $display("FAIL t1_wr_count got %0d want 3", wr_total - w0); else passed++;
    checks++;
    if (rd_total - r0 !== 3) $display("FAIL t1_rd_count got %0d want 3", rd_total - r0); else passed++;
    checks++;
    if (log_q.size() !== exp_q.size()) $display("FAIL t1_words got %0d want %0d", log_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i])
        $display("FAIL t1_word%0d got %h want %h", i, (i < log_q.size()) ? log_q[i] : ent_t'(0), exp_q[i]);
      else passed++;
    end
    checks++;
    if (rx_overflow !== 1'b0) $display("FAIL t1_overflow got %b want 0", rx_overflow); else passed++;
  endtask

  task automatic test_err_frame();
    log_q.delete(); exp_q.delete();
    send_frame(2, 2, 1'b1, -1, 1'b0);
    wait_drain();
    checks++;
    if (log_q.size() !== exp_q.size()) $display("FAIL t2_words got %0d want %0d", log_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i])
        $display("FAIL t2_word%0d got %h want %h", i, (i < log_q.size()) ? log_q[i] : ent_t'(0), exp_q[i]);
      else passed++;
    end
  endtask

  task automatic test_trunc();
    int w0;
    log_q.delete(); exp_q.delete();
    w0 = wr_total;
    send_frame(3, 5, 1'b0, 2, 1'b0);
    wait_drain();
    checks++;
    if (wr_total - w0 !== 2) $display("FAIL t3_wr_count got %0d want 2", wr_total - w0); else passed++;
    checks++;
    if (log_q.size() !== exp_q.size()) $display("FAIL t3_words got %0d want %0d", log_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i])
        $display("FAIL t3_word%0d got %h want %h", i, (i < log_q.size()) ? log_q[i] : ent_t'(0), exp_q[i]);
      else passed++;
    end
    checks++;
    if (rx_overflow !== 1'b1) $display("FAIL t3_overflow got %b want 1", rx_overflow); else passed++;
  endtask

  task automatic test_back_to_back();
    int w0, d0;
    rdy_mode = 0; log_q.delete(); exp_q.delete();
    for (int f = 0; f < FQ_DEPTH; f++) send_frame(10 + f, int'($urandom_range(1, 6)), 1'($urandom_range(0, 1)), -1, 1'b0);
    w0 = wr_total; d0 = drop_total;
    send_frame(10 + FQ_DEPTH, 3, 1'b0, -1, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (wr_total - w0 !== 0) $display("FAIL t4_drop_writes got %0d want 0", wr_total - w0); else passed++;
    checks++;
    if (drop_total - d0 !== 1) $display("FAIL t4_drop_pulses got %0d want 1", drop_total - d0); else passed++;
    checks++;
    if (log_q.size() !== 0) $display("FAIL t4_held_words got %0d want 0", log_q.size()); else passed++;
    rdy_mode = 1;
    wait_drain();
    checks++;
    if (log_q.size() !== exp_q.size()) $display("FAIL t4_words got %0d want %0d", log_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i])
        $display("FAIL t4_word%0d got %h want %h", i, (i < log_q.size()) ? log_q[i] : ent_t'(0), exp_q[i]);
      else passed++;
    end
    checks++;
    if (rx_overflow !== 1'b1) $display("FAIL t4_overflow got %b want 1", rx_overflow); else passed++;
  endtask

  task automatic test_random_ready();
    int w0, r0, e0, d0, sent;
    rdy_mode = 2; log_q.delete(); exp_q.delete();
    w0 = wr_total; r0 = rd_total; e0 = eof_total; d0 = drop_total; sent = 0;
    for (int f = 0; f < 12; f++) begin
      int t = 0;
      while (sent - (eof_total - e0) >= FQ_DEPTH && t < 2000) begin
        @(negedge clk);
        t++;
      end
      send_frame(100 + f, int'($urandom_range(1, 8)), 1'($urandom_range(0, 3) == 0), -1, 1'b0);
      sent++;
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    rdy_mode = 1;
    wait_drain();
    checks++;
    if (log_q.size() !== exp_q.size()) $display("FAIL t5_words got %0d want %0d", log_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i])
        $display("FAIL t5_word%0d got %h want %h", i, (i < log_q.size()) ? log_q[i] : ent_t'(0), exp_q[i]);
      else passed++;
    end
    checks++;
    if (rd_total - r0 !== wr_total - w0) $display("FAIL t5_rd_vs_wr got %0d want %0d", rd_total - r0, wr_total - w0);
    else passed++;
    checks++;
    if (drop_total - d0 !== 0) $display("FAIL t5_drops got %0d want 0", drop_total - d0); else passed++;
  endtask

  task automatic test_reset_mid();
    int w0, r0;
    rdy_mode = 0; log_q.delete(); exp_q.delete();
    send_frame(40, 6, 1'b0, -1, 1'b0);
    rdy_mode = 1;
    w0 = wr_total; r0 = rd_total;
    @(posedge clk); #1;
    receiving = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      cur_tok = {8'd41, 8'(i)};
    end
    @(posedge clk); #1;
    reset = 1'b0;
    receiving = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_total - w0 == 0 || rd_total - r0 == 0)
      $display("FAIL t6_activity got wr=%0d rd=%0d want both nonzero", wr_total - w0, rd_total - r0);
    else passed++;
    @(negedge clk);
    checks++;
    if ({fifo_wr_en, fifo_rd_en, rx_out_valid, rx_sof, rx_eof, rx_good_frame, rx_bad_frame, rx_drop, rx_overflow} !== 9'b0)
      $display("FAIL t6_reset_outputs got %b want 0", {fifo_wr_en, fifo_rd_en, rx_out_valid, rx_sof, rx_eof,
               rx_good_frame, rx_bad_frame, rx_drop, rx_overflow});
    else passed++;
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    log_q.delete(); exp_q.delete();
    send_frame(42, 3, 1'b0, -1, 1'b0);
    wait_drain();
    checks++;
    if (log_q.size() !== exp_q.size()) $display("FAIL t6_words got %0d want %0d", log_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i])
        $display("FAIL t6_word%0d got %h want %h", i, (i < log_q.size()) ? log_q[i] : ent_t'(0), exp_q[i]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_err_frame();
    test_trunc();
    test_back_to_back();
    test_random_ready();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
